// File: rtl/div_pkg.sv
// Shared definitions for the sequential integer divider: FSM states and func3 op codes.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_e;

    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_DIVU = 3'd5;
    localparam logic [2:0] OP_REM  = 3'd6;
    localparam logic [2:0] OP_REMU = 3'd7;

    function automatic logic op_is_valid(input logic [2:0] func3);
        return func3[2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] func3);
        return (func3 == OP_DIV) || (func3 == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] func3);
        return (func3 == OP_REM) || (func3 == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits and shift the quotient bit in. Purely combinational.
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_dvsr,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {i_rem, i_quo[W-1]};
        diff    = shifted - {1'b0, i_dvsr};
        // diff[W] is the borrow: set only when the divisor does not fit
        if (!diff[W]) begin
            o_rem = diff[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b1};
        end else begin
            o_rem = shifted[W-1:0];
            o_quo = {i_quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// Sequential DIV/DIVU/REM/REMU unit: o_done DATA_WIDTH+1 cycles after start, 1 cycle for special cases.
// Holds the pipeline via o_stall while busy; i_kill aborts, i_start is ignored unless IDLE.
module div_seq_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic                  i_kill,
    input  logic [2:0]            i_func3,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  is_rem_q, is_rem_d;

    logic [DATA_WIDTH-1:0] step_rem, step_quo;
    logic                  is_signed, a_neg, b_neg, div_zero, overflow;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;

    div_step #(.W(DATA_WIDTH)) u_step (
        .i_rem  (rem_q),
        .i_quo  (quo_q),
        .i_dvsr (dvsr_q),
        .o_rem  (step_rem),
        .o_quo  (step_quo)
    );

    always_comb begin
        is_signed = op_is_signed(i_func3);
        a_neg     = is_signed & i_dividend[DATA_WIDTH-1];
        b_neg     = is_signed & i_divisor[DATA_WIDTH-1];
        a_mag     = a_neg ? ('0 - i_dividend) : i_dividend;
        b_mag     = b_neg ? ('0 - i_divisor) : i_divisor;
        div_zero  = (i_divisor == '0);
        overflow  = is_signed & (i_dividend == MOST_NEG) & (i_divisor == '1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_kill) begin
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvsr_d   = b_mag;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    is_rem_d = op_is_rem(i_func3);
                    cnt_d    = CW'(DATA_WIDTH - 1);
                    state_d  = FINISH;
                    // Special cases resolve immediately and skip the iteration loop
                    if (!op_is_valid(i_func3)) begin
                        result_d = '0;
                    end else if (div_zero) begin
                        result_d = op_is_rem(i_func3) ? i_dividend : '1;
                    end else if (overflow) begin
                        result_d = op_is_rem(i_func3) ? '0 : i_dividend;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (i_kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = FINISH;
                        if (is_rem_q) begin
                            result_d = rneg_q ? ('0 - step_rem) : step_rem;
                        end else begin
                            result_d = qneg_q ? ('0 - step_quo) : step_quo;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
        end
    end

    // Outputs are forced low while reset is applied so a held i_start cannot stall the pipe
    assign o_stall  = !i_arst && (((state_q == IDLE) && i_start && !i_kill) || (state_q == CALC));
    assign o_done   = !i_arst && (state_q == FINISH);
    assign o_result = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Randomized scoreboard bench for div_seq_unit against an arithmetic reference model.
module tb_div_seq_unit;

    localparam int W = 64;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         arst, start, kill;
    logic [2:0]   f3;
    logic [W-1:0] a, b;
    logic         stall, done;
    logic [W-1:0] res;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    div_seq_unit #(.DATA_WIDTH(W)) dut (
        .i_clk      (clk),
        .i_arst     (arst),
        .i_start    (start),
        .i_kill     (kill),
        .i_func3    (f3),
        .i_dividend (a),
        .i_divisor  (b),
        .o_stall    (stall),
        .o_done     (done),
        .o_result   (res)
    );

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_exp;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        longint sx = x;
        longint sy = y;
        logic   ovf = (x == MOST_NEG) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
        case (f)
            3'd4:    if (y == 0) return '1; else if (ovf) return x; else return sx / sy;
            3'd5:    if (y == 0) return '1; else return x / y;
            3'd6:    if (y == 0) return x; else if (ovf) return '0; else return sx % sy;
            3'd7:    if (y == 0) return x; else return x % y;
            default: return '0;
        endcase
    endfunction

    // Cycles from start to o_done; -1 where the timing is not pinned down (unknown op codes)
    function automatic int ref_lat(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        if (f < 3'd4) return -1;
        if (y == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == MOST_NEG && y == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        return W + 1;
    endfunction

    task automatic drive_start(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        f3    = f;
        a     = x;
        b     = y;
    endtask

    task automatic push_exp(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y, output int lat);
        exp_t e;
        lat   = ref_lat(f, x, y);
        e.res = ref_res(f, x, y);
        e.due = (lat < 0) ? -1 : cyc + lat;
        last_exp = e.res;
        sb_q.push_back(e);
    endtask

    // Called in the start cycle; holds i_start (with changing operands) for 'hold' extra cycles
    task automatic wait_op(input string nm, input int lat, input int hold);
        int stall_cnt = 0;
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (stall) stall_cnt++;
            if (got && lat > 0) check({nm, "_stall_at_done"}, 64'(stall), 64'd0);
            if (i >= 1) begin
                f3 = 3'($urandom);
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
            end
            if (i == hold + 1 || got) start = 1'b0;
            if (got) break;
        end
        start = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no o_done within 200 cycles, expected o_done", nm);
            sb_q.delete();
        end else begin
            if (lat > 0) check({nm, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
            @(negedge clk);
            check({nm, "_result_hold"}, res, last_exp);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] f, input logic [63:0] x, input logic [63:0] y,
                         input int hold);
        int lat;
        drive_start(f, x, y);
        push_exp(f, x, y, lat);
        wait_op(nm, lat, (lat == W + 1) ? hold : 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        arst  = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        f3    = 3'd0;
        a     = '0;
        b     = '0;
        fork
            begin : stimulus
                int done_cnt;
                int lat;
                repeat (3) @(posedge clk);
                #1;
                arst = 1'b0;
                @(negedge clk);
                check("reset_stall", 64'(stall), 64'd0);
                check("reset_done", 64'(done), 64'd0);
                check("reset_result", res, 64'd0);

                issue("divu_100_7", 3'd5, 64'd100, 64'd7, 0);
                issue("remu_100_7", 3'd7, 64'd100, 64'd7, 0);
                issue("div_m100_7", 3'd4, -64'sd100, 64'd7, 3);
                issue("rem_m100_7", 3'd6, -64'sd100, 64'd7, 0);
                issue("divu_5_0", 3'd5, 64'd5, 64'd0, 0);
                issue("rem_m9_0", 3'd6, -64'sd9, 64'd0, 0);
                issue("div_ovf", 3'd4, MOST_NEG, '1, 0);
                issue("rem_ovf", 3'd6, MOST_NEG, '1, 0);
                issue("bad_op", 3'd2, 64'd77, 64'd5, 0);

                // kill together with start in IDLE: nothing accepted
                drive_start(3'd5, 64'd50, 64'd5);
                kill = 1'b1;
                @(negedge clk);
                check("kill_idle_stall", 64'(stall), 64'd0);
                @(posedge clk);
                #1;
                start = 1'b0;
                kill  = 1'b0;
                repeat (3) @(negedge clk);

                // kill in the middle of CALC
                drive_start(3'd5, '1, 64'd3);
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                kill = 1'b1;
                @(posedge clk);
                #1;
                kill = 1'b0;
                @(negedge clk);
                check("kill_calc_stall", 64'(stall), 64'd0);
                check("kill_calc_done", 64'(done), 64'd0);
                done_cnt = 0;
                repeat (70) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                check("kill_no_done", 64'(done_cnt), 64'd0);
                issue("divu_9_3_after_kill", 3'd5, 64'd9, 64'd3, 0);

                // reset mid-CALC with i_start held
                drive_start(3'd4, -64'sd1000, 64'd13);
                repeat (20) @(posedge clk);
                #1;
                arst = 1'b1;
                a    = 64'd123;
                @(negedge clk);
                check("arst_calc_stall", 64'(stall), 64'd0);
                check("arst_calc_done", 64'(done), 64'd0);
                @(posedge clk);
                #1;
                @(negedge clk);
                check("arst_result", res, 64'd0);
                check("arst_held_start_stall", 64'(stall), 64'd0);
                @(posedge clk);
                #1;
                arst = 1'b0;
                f3   = 3'd5;
                a    = 64'd9;
                b    = 64'd3;
                push_exp(3'd5, 64'd9, 64'd3, lat);
                wait_op("divu_9_3_after_arst", lat, 0);

                for (int n = 0; n < 40; n++) begin
                    logic [63:0] x, y;
                    logic [2:0]  f;
                    case ($urandom % 4)
                        0:       x = MOST_NEG;
                        1:       x = 64'($urandom_range(0, 1000));
                        default: x = {$urandom, $urandom};
                    endcase
                    case ($urandom % 5)
                        0:       y = '0;
                        1:       y = '1;
                        2:       y = ($urandom % 2) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
                        default: y = {$urandom, $urandom} >> ($urandom % 64);
                    endcase
                    f = ($urandom % 8 == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
                    issue("rand", f, x, y, int'($urandom % 6));
                end
                repeat (3) @(negedge clk);
            end
            begin : monitor
                forever begin
                    exp_t e;
                    @(negedge clk);
                    if (done) begin
                        if (sb_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_done: got o_done=1 at cycle %0d, expected none", cyc);
                        end else begin
                            e = sb_q.pop_front();
                            check("result", res, e.res);
                            if (e.due >= 0) check("done_cycle", 64'(cyc), 64'(e.due));
                        end
                    end
                end
            end
        join_any
        disable fork;
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
